// File: rtl/pipe_ctrl.sv
// Pipeline control for a five-stage CPU: merges per-stage stall requests
// into a per-stage hold vector, redirects the PC on exceptions/eret, and
// sequences the flush/refill window that follows a redirect.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_sat
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  localparam logic [31:0] EXC_VECTOR  = 32'h0000_0020;
  localparam logic [31:0] MISC_VECTOR = 32'h0000_0040;
  localparam logic [7:0]  CNT_MAX     = 8'hFF;

  state_e      state_q, state_d;
  logic [1:0]  refill_cnt_q, refill_cnt_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic [5:0]  req_stall;
  logic [31:0] redirect_pc;

  // Priority encode the stall requests: a stall in a later stage holds it
  // and every stage in front of it. WB (bit5) is never held.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    req_stall = 6'b000000;
    if (stallreq_mem)     req_stall = 6'b011111;
    else if (stallreq_ex) req_stall = 6'b001111;
    else if (stallreq_id) req_stall = 6'b000111;
    else if (stallreq_if) req_stall = 6'b000011;
  end

  // Map the exception code to its redirect target (eret returns to EPC).
  always_comb begin
    redirect_pc = MISC_VECTOR;
    unique case (excepttype_i)
      32'h0000_0001, 32'h0000_0008, 32'h0000_000a,
      32'h0000_000c, 32'h0000_000d: redirect_pc = EXC_VECTOR;
      32'h0000_000e:                redirect_pc = cp0_epc_i;
      default:                      redirect_pc = MISC_VECTOR;
    endcase
  end

  // Output decode: exceptions are only taken in RUN and beat any stall;
  // FLUSH is a dead cycle; everything is forced low while in reset.
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0000_0000;
    if (rst_n) begin
      if (state_q == ST_RUN && excepttype_i != 32'h0) begin
        flush  = 1'b1;
        new_pc = redirect_pc;
      end else if (state_q != ST_FLUSH) begin
        stall = req_stall;
      end
    end
  end

  // Next-state logic: one FLUSH cycle, then two REFILL cycles during which
  // exception codes from already-flushed slots are ignored.
  always_comb begin
    state_d      = state_q;
    refill_cnt_d = refill_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d      = ST_REFILL;
        refill_cnt_d = 2'd2;
      end
      ST_REFILL: begin
        refill_cnt_d = refill_cnt_q - 2'd1;
        if (refill_cnt_q == 2'd1) state_d = ST_RUN;
      end
      default: begin
        state_d      = ST_RUN;
        refill_cnt_d = 2'd0;
      end
    endcase
  end

  // Stall-cycle counter: counts consecutive held cycles, saturating.
  always_comb begin
    stall_cnt_d = 8'h00;
    if (!flush && stall != 6'b000000) begin
      stall_cnt_d = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + 8'd1;
    end
  end

  assign stall_sat = rst_n && (stall_cnt_q == CNT_MAX);

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= ST_RUN;
      refill_cnt_q <= 2'd0;
      stall_cnt_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      refill_cnt_q <= refill_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic,
// compared against a cycle-level behavioural model of the control rules.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_sat;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: cycles remaining in the post-redirect window (3 = the dead
  // flush cycle, 2..1 = refill), and consecutive stalled cycles.
  int busy = 0;
  int scnt = 0;

  logic last_flush;
  logic last_sat;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_sat    (stall_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Highest requesting stage h (if=1 .. mem=4) holds stages 0..h.
  function automatic logic [5:0] model_stall(input logic [3:0] req);
    int h = 0;
    for (int i = 0; i < 4; i++) if (req[i]) h = i + 1;
    return (h == 0) ? 6'd0 : 6'((1 << (h + 1)) - 1);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] et, input logic [31:0] epc);
    if (et == 32'h1 || et == 32'h8 || et == 32'ha || et == 32'hc || et == 32'hd) return 32'h20;
    if (et == 32'he) return epc;
    return 32'h40;
  endfunction

  // Drive one cycle of inputs (req = {mem, ex, id, if}), check the outputs
  // mid-cycle, then advance the model across the coming edge.
  task automatic run_cycle(input logic rn, input logic [3:0] req,
                           input logic [31:0] et, input logic [31:0] epc);
    logic        exc;
    logic [5:0]  e_stall;
    logic [31:0] e_pc;
    rst_n = rn;
    stallreq_if = req[0]; stallreq_id = req[1];
    stallreq_ex = req[2]; stallreq_mem = req[3];
    excepttype_i = et; cp0_epc_i = epc;
    @(negedge clk);
    exc     = rn && busy == 0 && et != 0;
    e_stall = (!rn || exc || busy == 3) ? 6'd0 : model_stall(req);
    e_pc    = exc ? model_target(et, epc) : 32'h0;
    check("stall", 32'(stall), 32'(e_stall));
    check("flush", 32'(flush), 32'(exc));
    check("new_pc", new_pc, e_pc);
    check("stall_sat", 32'(stall_sat), 32'(rn && scnt == 255));
    last_flush = flush;
    last_sat   = stall_sat;
    if (!rn) begin
      busy = 0;
      scnt = 0;
    end else begin
      busy = exc ? 3 : (busy > 0 ? busy - 1 : 0);
      scnt = (exc || e_stall == 0) ? 0 : (scnt < 255 ? scnt + 1 : 255);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int first_sat;
    logic [31:0] codes [7];
    codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3};

    rst_n = 1'b0;
    {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0;
    excepttype_i = 32'h0; cp0_epc_i = 32'h0;
    @(posedge clk); #1;

    // Reset, including inputs that would otherwise stall and flush.
    run_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
    run_cycle(1'b0, 4'b1111, 32'h8, 32'h0);

    // Stall priority: id+mem gives the MEM pattern; then each single request.
    run_cycle(1'b1, 4'b1010, 32'h0, 32'h0);
    run_cycle(1'b1, 4'b0001, 32'h0, 32'h0);
    run_cycle(1'b1, 4'b0010, 32'h0, 32'h0);
    run_cycle(1'b1, 4'b0100, 32'h0, 32'h0);
    run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);

    // Syscall beats a MEM stall; then FLUSH, two REFILL, RUN.
    run_cycle(1'b1, 4'b1000, 32'h8, 32'h0);
    check("syscall_flush", 32'(last_flush), 32'h1);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 4'b1000, 32'h0, 32'h0);

    // eret redirects to EPC; an unknown code goes to 0x40.
    run_cycle(1'b1, 4'b0000, 32'he, 32'h0000_1234);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);
    run_cycle(1'b1, 4'b0001, 32'h55, 32'h0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);

    // Overflow held four cycles: one pulse; held five: re-flush in RUN.
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, 4'b0000, 32'hc, 32'h0);
      pulses += int'(last_flush);
    end
    run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);
    check("ovf_hold4_pulses", 32'(pulses), 32'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b1, 4'b0000, 32'hc, 32'h0);
      pulses += int'(last_flush);
    end
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);
    check("ovf_hold5_pulses", 32'(pulses), 32'd2);

    // Long EX stall: saturation first seen on the 256th stalled cycle.
    first_sat = 0;
    for (int i = 1; i <= 300; i++) begin
      run_cycle(1'b1, 4'b0100, 32'h0, 32'h0);
      if (last_sat && first_sat == 0) first_sat = i;
    end
    check("sat_first_cycle", 32'(first_sat), 32'd256);
    run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);
    check("sat_on_drop", 32'(last_sat), 32'h1);
    run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);
    check("sat_after_drop", 32'(last_sat), 32'h0);

    // Reset during REFILL aborts the sequence; interrupt right after release.
    run_cycle(1'b1, 4'b0000, 32'hd, 32'h0);
    run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);
    run_cycle(1'b1, 4'b0010, 32'h0, 32'h0);
    run_cycle(1'b0, 4'b1111, 32'h1, 32'h0);
    run_cycle(1'b0, 4'b0000, 32'h1, 32'h0);
    run_cycle(1'b1, 4'b0000, 32'h1, 32'h0);
    check("rst_release_flush", 32'(last_flush), 32'h1);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);

    // Random traffic with occasional exceptions and resets.
    for (int i = 0; i < 2000; i++) begin
      logic        rn;
      logic [31:0] et;
      rn = ($urandom_range(0, 49) != 0);
      et = ($urandom_range(0, 9) == 0) ? codes[$urandom_range(0, 6)] : 32'h0;
      run_cycle(rn, 4'($urandom_range(0, 15)), et, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "time limit expired");
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk, rst_n.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock shared with all pipeline registers.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have port stallreq_if, input, 1 bit: fetch stage requests a stall (instruction bus wait).
REQ-005 The block SHALL have port stallreq_id, input, 1 bit: decode stage requests a stall (load-use hazard).
REQ-006 The block SHALL have port stallreq_ex, input, 1 bit: execute stage requests a stall (multi-cycle mul/div).
REQ-007 The block SHALL have port stallreq_mem, input, 1 bit: memory stage requests a stall (data bus wait).
REQ-008 The block SHALL have port excepttype_i, input, 32 bits: exception type of the instruction in MEM; 0 means none.
REQ-009 The block SHALL have port cp0_epc_i, input, 32 bits: current CP0 EPC value, used by eret.
REQ-010 The block SHALL have port stall, output, 6 bits: per-stage hold; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-011 The block SHALL have port flush, output, 1 bit: clears all pipeline registers at the next edge.
REQ-012 The block SHALL have port new_pc, output, 32 bits: redirect target, valid while flush=1.
REQ-013 The block SHALL have port stall_sat, output, 1 bit: the stall-cycle counter has saturated.

Function
REQ-014 The FSM SHALL have three states: RUN, FLUSH, REFILL (2-bit refill counter).
REQ-015 In RUN with excepttype_i != 0, flush SHALL be 1 in the same cycle (combinational), stall SHALL be 6'b000000, and the next state SHALL be FLUSH.
REQ-016 new_pc SHALL be 32'h00000020 for excepttype_i in {0x1 interrupt, 0x8 syscall, 0xa invalid inst, 0xc overflow, 0xd trap}, cp0_epc_i for 0xe (eret), and 32'h00000040 for any other nonzero value.
REQ-017 new_pc SHALL be 32'h00000000 whenever flush=0.
REQ-018 FLUSH SHALL last exactly one cycle with flush=0 and stall=0, then go to REFILL with the counter set to 2.
REQ-019 In REFILL, excepttype_i SHALL be ignored (stale flushed slots), the counter SHALL decrement each cycle, and the FSM SHALL return to RUN when the counter goes from 1 to 0 (2 REFILL cycles).
REQ-020 In RUN and REFILL without a flush, stall SHALL follow the highest-index request: stallreq_mem -> 6'b011111; stallreq_ex -> 6'b001111; stallreq_id -> 6'b000111; stallreq_if -> 6'b000011; none -> 6'b000000.
REQ-021 An exception SHALL take priority over every stall request in the same cycle.
REQ-022 stall_cnt (8 bits, internal) SHALL increment on each cycle with stall != 0, saturate at 255, and clear on any cycle with stall == 0 or flush == 1.
REQ-023 stall_sat SHALL be 1 while stall_cnt == 255 (registered; it is an observation flag only).
REQ-024 The WB stall bit (bit5) SHALL never be asserted.

Reset
REQ-025 While rst_n=0 at a clock edge, the next state SHALL be RUN, the refill counter 0, and stall_cnt 0.
REQ-026 While rst_n=0, outputs SHALL be forced to stall=0, flush=0, new_pc=0 and stall_sat=0, regardless of inputs.
REQ-027 Reset asserted in FLUSH or REFILL SHALL abort the sequence; the first cycle after release SHALL be RUN.

Verification
REQ-028 stallreq_id=1 and stallreq_mem=1 with no exception -> stall=6'b011111, flush=0.
REQ-029 excepttype_i=0x8 with stallreq_mem=1 in RUN -> same cycle flush=1, new_pc=0x00000020, stall=0; then one FLUSH cycle, two REFILL cycles, RUN.
REQ-030 excepttype_i=0xe with cp0_epc_i=0x0000_1234 -> flush=1, new_pc=0x00001234.
REQ-031 excepttype_i=0xc held for four cycles -> exactly one flush pulse; the REFILL cycles ignore it; it re-flushes on the first RUN cycle if it is still present.
REQ-032 stallreq_ex held for 300 cycles -> stall_sat=1 from the 256th stalled cycle onward; it clears the cycle after stallreq_ex drops.
REQ-033 rst_n=0 asserted during REFILL -> all outputs 0; after release, excepttype_i=0x1 -> immediate flush with new_pc=0x00000020.
